fp_div_ctrl: RTL and testbench
==============================

// Module: fp_div_ctrl
// PURPOSE
//   Front-end sequencer for the single-precision IEEE754 divider `div`.
//   Accepts one N/D operand pair per valid/ready handshake and classifies both operands.
//   Special-case operands are resolved locally. Finite normal pairs are driven
//   to the divider (div_n/div_d), the block waits DIV_LATENCY clocks, then captures div_o.
//   The result and exception flags are held on a valid/ready output port until consumed.
// PARAMETERS
//   DIV_LATENCY  1             clocks from div_n/div_d stable to div_o valid; legal range 1..15
//   QNAN         32'h7FC00000  canonical quiet NaN returned for invalid operations
// PORTS
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous, active-low reset
//   in_valid    in   1   operand pair offered
//   in_ready    out  1   block can accept; high only in IDLE
//   in_a        in   32  dividend N (IEEE754 single)
//   in_b        in   32  divisor D (IEEE754 single)
//   div_n       out  32  registered dividend to div
//   div_d       out  32  registered divisor to div
//   div_o       in   32  quotient from div
//   out_valid   out  1   result available
//   out_ready   in   1   consumer takes result
//   out_result  out  32  quotient (IEEE754 single)
//   out_invalid out  1   invalid-operation flag for this result
//   out_dz      out  1   divide-by-zero flag for this result
//   busy        out  1   high in WAIT or DONE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, cnt=0.
//     div_n, div_d, out_result, out_invalid, out_dz, out_valid and busy all clear to 0.
//     in_ready=1 once rst_n=1. Reset in WAIT/DONE discards the op; no stale out_valid.
//   FSM states: IDLE, WAIT, DONE.
//     IDLE: in_ready=1. Accept when in_valid&&in_ready, which latches in_a->div_n and in_b->div_d.
//       If the pair is special: load result/flags -> DONE.
//       Otherwise: cnt<=DIV_LATENCY -> WAIT.
//     WAIT: cnt decrements each clock. When cnt==1: out_result<=div_o, flags<=0 -> DONE.
//     DONE: out_valid=1. out_result/flags/div_n/div_d are stable.
//       Leave for IDLE when out_ready=1; in_valid is ignored in DONE.
//   Latency (accept in cycle 0):
//     special: out_valid in cycle 1.
//     divided: out_valid in cycle DIV_LATENCY+1.
//     Minimum spacing between accepts is 2 cycles; there is no overlap of operations.
//   div_n/div_d change only at accept and hold through WAIT/DONE/IDLE until the next accept.
//   Classification: s=a[31]^b[31]; an operand is zero when exp==0 (denormals flushed, DAZ).
//     Inf is exp==FF with frac==0; NaN is exp==FF with frac!=0.
//   Special priority (first match wins):
//     1 a or b NaN            -> QNAN,             invalid=1
//     2 Inf/Inf or 0/0        -> QNAN,             invalid=1
//     3 a Inf                 -> {s,8'hFF,23'h0}
//     4 b zero (a nonzero)    -> {s,8'hFF,23'h0},  dz=1
//     5 a zero or b Inf       -> {s,31'h0}
//   Divided results pass div_o through unmodified; both flags are 0.
//   Flags are valid only while out_valid=1 and are cleared on the next accept.
// TESTING
//   - 0xC0700000/0x3FC00000 with model div_o=0xC0200000, L=1
//       -> out_result=0xC0200000 in cycle 2, flags 0.
//   - 0x40900000/0x00000000
//       -> out_result=0x7F800000, out_dz=1, out_valid in cycle 1.
//   - 0x7F800000/0x7F800000
//       -> out_result=0x7FC00000, out_invalid=1; 0x00000000/0x00000000 gives the same.
//   - 0x42480000/0xC1C80000 with L=3, model div_o=0xC0000000
//       -> 0xC0000000 in cycle 4; div_n/div_d stable through cycles 1-3.
//   - out_ready low 5 cycles in DONE with in_valid=1 held
//       -> result/flags stable, in_ready=0, second op accepted only after handshake.
//   - rst_n pulsed low in WAIT
//       -> out_valid/busy=0 immediately, in_ready=1 after release, no result emitted.

Source files
------------

// File: rtl/fp_div_if.sv
// Handshake and divider-side signal bundle for the fp_div_ctrl sequencer.
// The slave modport is the controller; the master modport is its environment.
interface fp_div_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] div_n;
    logic [31:0] div_d;
    logic [31:0] div_o;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_invalid;
    logic        out_dz;
    logic        busy;

    modport slave (
        input  in_valid, in_a, in_b, div_o, out_ready,
        output in_ready, div_n, div_d, out_valid, out_result, out_invalid, out_dz, busy
    );

    modport master (
        output in_valid, in_a, in_b, div_o, out_ready,
        input  in_ready, div_n, div_d, out_valid, out_result, out_invalid, out_dz, busy
    );
endinterface

// File: rtl/fp_div_ctrl.sv
// Front-end sequencer for a single-precision divider: resolves IEEE special
// operands locally and times the external divider for finite pairs.
//
// state  | meaning
// S_IDLE | ready for a new operand pair
// S_WAIT | divider running, cnt counts down to capture
// S_DONE | result held on the output port until consumed
module fp_div_ctrl #(
    parameter int unsigned DIV_LATENCY = 1,
    parameter logic [31:0] QNAN        = 32'h7FC00000
) (
    input  logic    clk,
    input  logic    rst_n,
    fp_div_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] LAT = 4'(DIV_LATENCY);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        accept;
    logic        sgn;
    logic        a_zero, a_inf, a_nan;
    logic        b_zero, b_inf, b_nan;
    logic        special;
    logic [31:0] spec_res;
    logic        spec_inv;
    logic        spec_dz;

    // Denormals count as zero (exponent field only).
    assign sgn    = bus.in_a[31] ^ bus.in_b[31];
    assign a_zero = (bus.in_a[30:23] == 8'h00);
    assign b_zero = (bus.in_b[30:23] == 8'h00);
    assign a_inf  = (bus.in_a[30:23] == 8'hFF) && (bus.in_a[22:0] == 23'h0);
    assign b_inf  = (bus.in_b[30:23] == 8'hFF) && (bus.in_b[22:0] == 23'h0);
    assign a_nan  = (bus.in_a[30:23] == 8'hFF) && (bus.in_a[22:0] != 23'h0);
    assign b_nan  = (bus.in_b[30:23] == 8'hFF) && (bus.in_b[22:0] != 23'h0);

    always_comb begin
        special  = 1'b1;
        spec_res = 32'h0;
        spec_inv = 1'b0;
        spec_dz  = 1'b0;
        if (a_nan || b_nan) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if (a_inf) begin
            spec_res = {sgn, 8'hFF, 23'h0};
        end else if (b_zero) begin
            spec_res = {sgn, 8'hFF, 23'h0};
            spec_dz  = 1'b1;
        end else if (a_zero || b_inf) begin
            spec_res = {sgn, 31'h0};
        end else begin
            special  = 1'b0;
        end
    end

    assign accept = bus.in_valid && (state == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept)           state_nxt = special ? S_DONE : S_WAIT;
            S_WAIT: if (cnt == 4'd1)      state_nxt = S_DONE;
            S_DONE: if (bus.out_ready)    state_nxt = S_IDLE;
            default:                      state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == S_IDLE);
        bus.out_valid = (state == S_DONE);
        bus.busy      = (state == S_WAIT) || (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= 4'd0;
            bus.div_n       <= 32'h0;
            bus.div_d       <= 32'h0;
            bus.out_result  <= 32'h0;
            bus.out_invalid <= 1'b0;
            bus.out_dz      <= 1'b0;
        end else if (accept) begin
            bus.div_n       <= bus.in_a;
            bus.div_d       <= bus.in_b;
            bus.out_invalid <= spec_inv;
            bus.out_dz      <= spec_dz;
            if (special) begin
                bus.out_result <= spec_res;
                cnt            <= 4'd0;
            end else begin
                cnt            <= LAT;
            end
        end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                bus.out_result  <= bus.div_o;
                bus.out_invalid <= 1'b0;
                bus.out_dz      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_div_ctrl.sv
// Scoreboard bench for fp_div_ctrl: a stub divider whose output is only
// meaningful after DIV_LATENCY clocks, random operands, and a classifying model.
module tb_fp_div_ctrl;

    localparam int          L    = 3;
    localparam logic [31:0] QNAN = 32'h7FC00000;

    typedef enum {C_ZERO, C_NORM, C_INF, C_NAN} cls_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        inv;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    fp_div_if bus();

    fp_div_ctrl #(.DIV_LATENCY(L), .QNAN(QNAN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          stable = 0;
    logic [31:0] pn = 32'h0;
    logic [31:0] pd = 32'h0;
    logic        hold_low = 1'b0;
    logic        prev_valid = 1'b0;
    logic [33:0] held = 34'h0;

    function automatic logic [31:0] div_model(input logic [31:0] n, input logic [31:0] d);
        if (n == 32'hC0700000 && d == 32'h3FC00000) return 32'hC0200000;
        if (n == 32'h42480000 && d == 32'hC1C80000) return 32'hC0000000;
        return (n * 32'd2654435761) ^ {d[7:0], d[31:8]};
    endfunction

    function automatic cls_t cls(input logic [31:0] x);
        if (x[30:23] == 8'h00) return C_ZERO;
        if (x[30:23] != 8'hFF) return C_NORM;
        return (x[22:0] == 23'h0) ? C_INF : C_NAN;
    endfunction

    function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        cls_t ca = cls(a);
        cls_t cb = cls(b);
        logic s = a[31] ^ b[31];
        e.a = a; e.b = b; e.inv = 1'b0; e.dz = 1'b0; e.lat = 1; e.acc = 0;
        if (ca == C_NAN || cb == C_NAN || (ca == cb && (ca == C_INF || ca == C_ZERO))) begin
            e.res = QNAN; e.inv = 1'b1;
        end else if (ca == C_INF) begin
            e.res = {s, 8'hFF, 23'h0};
        end else if (cb == C_ZERO) begin
            e.res = {s, 8'hFF, 23'h0}; e.dz = 1'b1;
        end else if (ca == C_ZERO || cb == C_INF) begin
            e.res = {s, 31'h0};
        end else begin
            e.res = div_model(a, b); e.lat = L + 1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] x = $urandom;
        case ($urandom_range(0, 5))
            0:       x[30:23] = 8'h00;
            1:       begin x[30:23] = 8'hFF; x[22:0] = 23'h0; end
            2:       begin x[30:23] = 8'hFF; x[22:0] = 23'($urandom_range(1, 23'h7FFFFF)); end
            default: x[30:23] = 8'($urandom_range(1, 254));
        endcase
        return x;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Stub divider: returns garbage until its inputs have been stable L clocks.
    always @(negedge clk) begin
        if (bus.div_n !== pn || bus.div_d !== pd) stable = 0;
        else stable++;
        pn = bus.div_n;
        pd = bus.div_d;
    end
    assign bus.div_o = (stable >= L - 1) ? div_model(bus.div_n, bus.div_d) : 32'hBAD00BAD;

    always @(posedge clk) begin
        cyc++;
        #1;
        bus.out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 64'(bus.out_result), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    if (!prev_valid) begin
                        chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
                        chk("div_n_held", 64'(bus.div_n), 64'(q[0].a));
                        chk("div_d_held", 64'(bus.div_d), 64'(q[0].b));
                    end else begin
                        chk("done_stable", 64'({bus.out_result, bus.out_invalid, bus.out_dz}), 64'(held));
                    end
                    chk("in_ready_done", 64'(bus.in_ready), 64'd0);
                    if (bus.out_ready) begin
                        chk("result", 64'(bus.out_result), 64'(q[0].res));
                        chk("flags", 64'({bus.out_invalid, bus.out_dz}), 64'({q[0].inv, q[0].dz}));
                        void'(q.pop_front());
                    end
                end
            end
            prev_valid = bus.out_valid;
            held = {bus.out_result, bus.out_invalid, bus.out_dz};
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   guard = 0;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            guard++;
            if (guard > 100) begin
                chk("accept_timeout", 64'd0, 64'd1);
                bus.in_valid = 1'b0;
                return;
            end
        end
        e = ref_model(a, b);
        e.acc = cyc;
        q.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a = $urandom;
        bus.in_b = $urandom;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        bus.in_valid = 1'b0;
        bus.in_a = 32'h0;
        bus.in_b = 32'h0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_div_nd", 64'({bus.div_n, bus.div_d}), 64'd0);
        chk("rst_result", 64'({bus.out_result, bus.out_invalid, bus.out_dz}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        send(32'hC0700000, 32'h3FC00000);
        send(32'h40900000, 32'h00000000);
        send(32'h7F800000, 32'h7F800000);
        send(32'h00000000, 32'h00000000);
        send(32'h42480000, 32'hC1C80000);

        // Long DONE stall with a second request already pending.
        hold_low = 1'b1;
        fork
            begin
                repeat (8) @(posedge clk);
                hold_low = 1'b0;
            end
            begin
                send(32'h40900000, 32'h00000000);
                send(32'hC1C80000, 32'h40000000);
            end
        join

        // Reset while the divider is in flight.
        guard = 0;
        while (q.size() != 0 && guard < 200) begin @(posedge clk); guard++; end
        #1;
        send(32'h3F800000, 32'h40400000);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_wait_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_wait_busy", 64'(bus.busy), 64'd0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_wait_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (6) @(posedge clk);
        #1;

        for (int i = 0; i < 250; i++) begin
            send(rand_op(), rand_op());
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
            #1;
        end

        guard = 0;
        while (q.size() != 0 && guard < 500) begin @(posedge clk); guard++; end
        chk("drain", 64'(q.size()), 64'd0);
        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
